// File: rtl/polyq_accumulate_if.sv
// polyq_accumulate_if
// Groups every non-clock signal of polyq_accumulate into one bundle:
//   run control : start, max -> acc_done, addr_err
//   term stream : in_valid, in_addr, in_coef, in_sub, in_last -> in_ready
//   memory port : mem_output -> mem_address_i, mem_input, write_enable
// Modports:
//   slave  - the accumulator's view (consumes terms, drives the memory port)
//   master - the environment's view (term source and polynomial memory)
interface polyq_accumulate_if;
  logic        start;
  logic [10:0] max;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_addr;
  logic [12:0] in_coef;
  logic        in_sub;
  logic        in_last;
  logic [10:0] mem_address_i;
  logic [12:0] mem_output;
  logic [12:0] mem_input;
  logic        write_enable;
  logic        acc_done;
  logic        addr_err;

  modport slave (
    input  start, max, in_valid, in_addr, in_coef, in_sub, in_last, mem_output,
    output in_ready, mem_address_i, mem_input, write_enable, acc_done, addr_err
  );

  modport master (
    output start, max, in_valid, in_addr, in_coef, in_sub, in_last, mem_output,
    input  in_ready, mem_address_i, mem_input, write_enable, acc_done, addr_err
  );
endinterface

// File: rtl/polyq_accumulate.sv
// polyq_accumulate
// Read-modify-write accumulator on the single-port polynomial memory.
// Each accepted term is reduced mod q = 4591, combined with the stored
// coefficient (mod q) and written back; one term every 4 cycles.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - polyq_accumulate_if.slave (run control, term stream, memory port)
// Build option:
//   POLYQ_ACC_SUB_EN - when defined, in_sub=1 selects modular subtraction;
//                      when undefined in_sub is ignored and every term adds.
module polyq_accumulate (
  input logic                   clk,
  input logic                   rst_n,
  polyq_accumulate_if.slave     bus
);

  localparam logic [12:0] Q13 = 13'd4591;
  localparam logic [13:0] Q14 = 14'd4591;

  typedef enum logic [2:0] {IDLE, RUN, RD, ADD, WR, DONE} state_t;

  state_t      state_reg, state_next;
  logic [10:0] max_reg;
  logic [10:0] addr_reg;
  logic [12:0] coef_reg;
  logic        last_reg;
  logic [12:0] r_reg;
  logic        addr_err_reg;

  logic        accept;
  logic        in_range;
  logic [12:0] c_red;
  logic [13:0] sum;
  logic [12:0] r_add;
  logic [12:0] r_next;

`ifdef POLYQ_ACC_SUB_EN
  logic        sub_reg;
  logic [12:0] r_sub;
`endif

  assign accept   = (state_reg == RUN) && bus.in_valid;
  assign in_range = (bus.in_addr <= max_reg);

  // Terms may be up to 8191 < 2q, so one conditional subtract fully reduces them.
  assign c_red = (coef_reg >= Q13) ? (coef_reg - Q13) : coef_reg;
  assign sum   = {1'b0, bus.mem_output} + {1'b0, c_red};
  assign r_add = 13'((sum >= Q14) ? (sum - Q14) : sum);

`ifdef POLYQ_ACC_SUB_EN
  // On borrow, a - c + q evaluated with 13-bit wraparound lands in 1..q-1.
  assign r_sub  = (bus.mem_output >= c_red) ? (bus.mem_output - c_red)
                                            : (bus.mem_output - c_red + Q13);
  assign r_next = sub_reg ? r_sub : r_add;
`else
  assign r_next = r_add;
`endif

  // State register; the asynchronous clear drops write_enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        if (accept) begin
          if (!in_range) state_next = bus.in_last ? DONE : RUN;
          else           state_next = RD;
        end
      end
      RD:      state_next = ADD;
      ADD:     state_next = WR;
      WR:      state_next = last_reg ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_reg      <= '0;
      addr_reg     <= '0;
      coef_reg     <= '0;
      last_reg     <= 1'b0;
      r_reg        <= '0;
      addr_err_reg <= 1'b0;
`ifdef POLYQ_ACC_SUB_EN
      sub_reg      <= 1'b0;
`endif
    end else begin
      if (state_reg == IDLE && bus.start) begin
        max_reg      <= bus.max;
        addr_err_reg <= 1'b0;
      end
      if (accept) begin
        addr_reg <= bus.in_addr;
        coef_reg <= bus.in_coef;
        last_reg <= bus.in_last;
`ifdef POLYQ_ACC_SUB_EN
        sub_reg  <= bus.in_sub;
`endif
        if (!in_range) addr_err_reg <= 1'b1;
      end
      if (state_reg == ADD) r_reg <= r_next;
    end
  end

  // Outputs decode the state register or come straight from registers.
  assign bus.in_ready      = (state_reg == RUN);
  assign bus.write_enable  = (state_reg == WR);
  assign bus.acc_done      = (state_reg == DONE);
  assign bus.addr_err      = addr_err_reg;
  assign bus.mem_address_i = (state_reg == RD || state_reg == WR) ? addr_reg : 11'd0;
  assign bus.mem_input     = r_reg;

endmodule

// File: tb/tb_polyq_accumulate.sv
`timescale 1ns/1ps
// tb_polyq_accumulate
// Drives randomized and directed terms into polyq_accumulate over a
// behavioural memory; expected write-backs go into a scoreboard queue that a
// monitor compares against every write strobe.
module tb_polyq_accumulate;

  localparam int Q = 4591;
`ifdef POLYQ_ACC_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  polyq_accumulate_if bus();

  polyq_accumulate dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port memory with registered read.
  logic [12:0] mem [0:2047];
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [12:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.write_enable) mem[bus.mem_address_i] <= bus.mem_input;
    bus.mem_output <= mem[bus.mem_address_i];
  end

  int ref_mem [0:2047];
  int max_m = 0;
  bit err_m = 1'b0;

  typedef struct { int addr; int data; } wr_t;
  wr_t sb_q[$];
  wr_t mon_e;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain modular add/subtract of the reduced term.
  function automatic int model_result(input int a, input int c, input bit s);
    int cr;
    cr = c % Q;
    if (s && SUB_EN) return (a - cr + Q) % Q;
    return (a + cr) % Q;
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_enable) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("wr_addr", int'(bus.mem_address_i), mon_e.addr);
          chk("wr_data", int'(bus.mem_input), mon_e.data);
        end
        $display("[TB] write addr=%0d data=%0d", bus.mem_address_i, bus.mem_input);
      end
      if (bus.acc_done) done_cnt++;
    end
  end

  task automatic preload(input int a, input int v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 11'(a); pre_data = 13'(v);
    ref_mem[a] = v;
  endtask

  task automatic start_run(input int mx);
    @(negedge clk);
    bus.start = 1'b1;
    bus.max   = 11'(mx);
    @(negedge clk);
    bus.start = 1'b0;
    max_m = mx;
    err_m = 1'b0;
    chk("run_ready", int'(bus.in_ready), 1);
    chk("err_clear", int'(bus.addr_err), 0);
    $display("[TB] start max=%0d", mx);
  endtask

  // Present a term and return just after the accepting edge.
  task automatic accept(input int a, input int c, input bit s, input bit last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_addr  = 11'(a);
    bus.in_coef  = 13'(c);
    bus.in_sub   = s;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic term(input int a, input int c, input bit s, input bit last, input bit poke);
    bit drop;
    int r;
    int d0;
    d0   = done_cnt;
    drop = (a > max_m);
    r    = 0;
    if (!drop) begin
      r = model_result(ref_mem[a], c, s);
      sb_q.push_back('{a, r});
      ref_mem[a] = r;
    end else begin
      err_m = 1'b1;
    end
    $display("[TB] term addr=%0d coef=%0d sub=%0d last=%0d drop=%0d exp=%0d", a, c, s, last, drop, r);
    accept(a, c, s, last);
    if (drop) begin
      @(negedge clk);
      chk("drop_err", int'(bus.addr_err), 1);
      chk("drop_done", int'(bus.acc_done), int'(last));
      chk("drop_ready", int'(bus.in_ready), int'(!last));
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("busy_ready", int'(bus.in_ready), 0);
        if (poke && i == 0) begin
          bus.start = 1'b1;
          bus.max   = 11'd0;
        end
        if (i == 1) bus.start = 1'b0;
      end
      @(negedge clk);
      chk("post_done", int'(bus.acc_done), int'(last));
      chk("post_ready", int'(bus.in_ready), int'(!last));
    end
    if (last) begin
      @(negedge clk);
      chk("done_single", done_cnt - d0, 1);
      chk("err_final", int'(bus.addr_err), int'(err_m));
      chk("idle_ready", int'(bus.in_ready), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r9;
    int bad;
    bus.start = 1'b0; bus.max = '0; bus.in_valid = 1'b0; bus.in_addr = '0;
    bus.in_coef = '0; bus.in_sub = 1'b0; bus.in_last = 1'b0;

    // Clear memory while held in reset, then seed two directed values.
    for (int i = 0; i < 2048; i++) preload(i, 0);
    preload(0, 4500);
    preload(3, 10);
    @(negedge clk);
    pre_we = 1'b0;

    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_we", int'(bus.write_enable), 0);
    chk("rst_done", int'(bus.acc_done), 0);
    chk("rst_err", int'(bus.addr_err), 0);
    chk("rst_addr", int'(bus.mem_address_i), 0);
    chk("rst_data", int'(bus.mem_input), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_ready", int'(bus.in_ready), 0);

    // Two terms to the same address.
    start_run(756);
    term(5, 100, 1'b0, 1'b0, 1'b0);
    term(5, 200, 1'b0, 1'b1, 1'b0);
    chk("mem5", int'(mem[5]), 300);

    // Wraparound, oversize coefficient, optional subtract.
    start_run(756);
    term(0, 200, 1'b0, 1'b0, 1'b0);
    term(9, 50, 1'b0, 1'b0, 1'b0);
    term(17, 8191, 1'b0, 1'b0, 1'b0);
    term(3, 20, 1'b1, 1'b1, 1'b0);
    chk("mem0", int'(mem[0]), 109);
    chk("mem17", int'(mem[17]), 3600);
    chk("mem3", int'(mem[3]), SUB_EN ? 4581 : 30);

    // Out-of-range last term, then boundary address in the next run.
    start_run(756);
    term(757, 5, 1'b0, 1'b1, 1'b0);
    start_run(756);
    term(756, 1, 1'b0, 1'b1, 1'b0);

    // start during RD must not disturb the run or max_r.
    start_run(756);
    term(20, 33, 1'b0, 1'b0, 1'b1);
    term(700, 3, 1'b0, 1'b1, 1'b0);

    // Reset in the write cycle: strobe drops at once, memory untouched.
    start_run(756);
    r9 = model_result(ref_mem[9], 77, 1'b0);
    sb_q.push_back('{9, r9});
    accept(9, 77, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("we_in_wr", int'(bus.write_enable), 1);
    #2 rst_n = 1'b0;
    #1 chk("we_async_drop", int'(bus.write_enable), 0);
    @(posedge clk);
    #1 chk("mem9_kept", int'(mem[9]), ref_mem[9]);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.in_ready), 0);
    chk("post_rst_err", int'(bus.addr_err), 0);
    chk("post_rst_addr", int'(bus.mem_address_i), 0);
    chk("post_rst_data", int'(bus.mem_input), 0);
    chk("post_rst_done", int'(bus.acc_done), 0);
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(bus.in_ready), 0);

    // Randomized runs including near-boundary and out-of-range addresses.
    for (int run = 0; run < 8; run++) begin
      int mx;
      int nt;
      mx = $urandom_range(2046, 20);
      nt = $urandom_range(8, 4);
      start_run(mx);
      for (int t = 0; t < nt; t++) begin
        int a;
        int sel;
        sel = $urandom_range(9, 0);
        if (sel == 0)      a = mx + 1;
        else if (sel == 1) a = mx;
        else if (sel == 2) a = $urandom_range(9, 0);
        else               a = $urandom_range(mx, 0);
        term(a, $urandom_range(8191, 0), 1'($urandom_range(1, 0)), t == nt - 1, 1'b0);
      end
    end

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (int'(mem[i]) != ref_mem[i]) bad++;
    chk("mem_sweep", bad, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
